// File: rtl/sub32_pkg.sv
// Shared constants and FSM state type for the serial 32-bit subtractor.
// WIDTH/DIGIT/STEPS sizing, nibble counter width, and state encodings.
package sub32_pkg;

    localparam int WIDTH = 32;
    localparam int DIGIT = 4;
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = 3;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/sub_4.sv
// Combinational 4-bit subtractor with borrow chain: {bout, d} = a - b - bin.
// Ports: a, b (4-bit operands), bin (borrow in) -> d (difference), bout.
module sub_4
    import sub32_pkg::*;
(
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] diff;

    // Extra MSB of the widened difference is the borrow out.
    assign diff = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
    assign d    = diff[DIGIT-1:0];
    assign bout = diff[DIGIT];

endmodule

// File: rtl/sub_32_serial.sv
// Serial 32-bit unsigned subtractor, one nibble per cycle, valid/ready I/O.
// Ports: clk, rst_n, in_valid/in_ready, A, B, out_valid/out_ready, D, Bout, Z.
// Build option SUB32_SATURATE_EN: clamp D to 0 (Z=1) when A < B.
module sub_32_serial
    import sub32_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             Z
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             z_q, z_d;

    logic [DIGIT-1:0] nib_d;
    logic             nib_bout;
    logic [WIDTH-1:0] res_shift;

    // Operands shift right, so the active nibble is always the low one.
    sub_4 u_sub (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .bin  (brw_q),
        .d    (nib_d),
        .bout (nib_bout)
    );

    // New nibble enters at the top; after STEPS shifts nibble 0 is at LSB.
    assign res_shift = {nib_d, res_q[WIDTH-1:DIGIT]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        z_d     = z_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    bout_d  = 1'b0;
                    z_d     = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                res_d = res_shift;
                brw_d = nib_bout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                    bout_d  = nib_bout;
                    z_d     = (res_shift == '0);
`ifdef SUB32_SATURATE_EN
                    if (nib_bout) begin
                        res_d = '0;
                        z_d   = 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            z_q     <= z_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign D         = res_q;
    assign Bout      = bout_q;
    assign Z         = z_q;

endmodule

// File: tb/tb_sub_32_serial.sv
// Scoreboard bench for sub_32_serial: driver issues operand pairs,
// a negedge monitor predicts handshakes and checks results against a model.
module tb_sub_32_serial;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] D;
    logic        Bout;
    logic        Z;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_edge = 0;
    bit busy = 0;
    logic [33:0] q[$];

    sub_32_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .Z         (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [33:0] model(input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] d;
        logic        bo;
        d  = a - b;
        bo = (a < b);
`ifdef SUB32_SATURATE_EN
        if (bo) d = 32'd0;
`endif
        return {d, bo, (d == 32'd0)};
    endfunction

    // Monitor: values seen at negedge are what the next posedge samples.
    always @(negedge clk) begin
        logic [33:0] exp_r;
        logic        exp_ov;
        if (rst_n) begin
            checks++;
            if (in_ready !== !busy) begin
                errors++;
                $display("FAIL in_ready cyc=%0d got=%b exp=%b",
                         cyc, in_ready, !busy);
            end
            exp_ov = busy && (cyc >= acc_edge + 8);
            checks++;
            if (out_valid !== exp_ov) begin
                errors++;
                $display("FAIL out_valid cyc=%0d got=%b exp=%b",
                         cyc, out_valid, exp_ov);
            end
            if (out_valid === 1'b1 && busy) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL result_unexpected cyc=%0d got=%h exp=none",
                             cyc, D);
                end else begin
                    exp_r = q[0];
                    if ({D, Bout, Z} !== exp_r) begin
                        errors++;
                        $display("FAIL result cyc=%0d got D=%h B=%b Z=%b exp D=%h B=%b Z=%b",
                                 cyc, D, Bout, Z,
                                 exp_r[33:2], exp_r[1], exp_r[0]);
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        busy = 0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(A, B));
                busy     = 1;
                acc_edge = cyc + 1;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL idle_timeout got=busy exp=idle");
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b);
        int n;
        @(posedge clk);
        #1;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        n        = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 40);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle();
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || D !== 32'd0 ||
            Bout !== 1'b0 || Z !== 1'b0) begin
            errors++;
            $display("FAIL %s got rdy=%b ov=%b D=%h B=%b Z=%b exp rdy=1 ov=0 D=0 B=0 Z=0",
                     tag, in_ready, out_valid, D, Bout, Z);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        #2;
        check_reset_vals("reset_init");
        #20;
        rst_n = 1'b1;

        do_op(32'd5, 32'd3);
        do_op(32'd0, 32'd1);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(32'h8000_0000, 32'h0000_0001);
        do_op(32'h1234_5678, 32'h1234_5678);

        // Backpressure: hold result, try to inject other operands.
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        A        = 32'd100;
        B        = 32'd200;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 12 && out_valid !== 1'b1; i++) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = i[0];
            A        = $urandom;
            B        = $urandom;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Reset during RUN.
        @(posedge clk);
        #1;
        A        = 32'd10;
        B        = 32'd4;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        busy  = 0;
        q.delete();
        #1;
        check_reset_vals("reset_mid_run");
        #2;
        rst_n = 1'b1;
        do_op(32'd10, 32'd4);

        // Continuous in_valid with changing operands and random out_ready.
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            A         = $urandom;
            B         = (i % 3 == 0) ? A : $urandom;
            out_ready = $urandom_range(0, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Random single operations.
        for (int i = 0; i < 25; i++) begin
            do_op($urandom, $urandom);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
